// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PCF, runs the req/ack instruction-memory port and loads
// the F/D pipeline register. Responses to requests overtaken by a redirect are discarded.
module fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            BranchTakenE,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic            PCSrcW,
  input  logic [XLEN-1:0] ResultW,
  output logic            IMemReq,
  output logic [XLEN-1:0] IMemAddr,
  input  logic            IMemAck,
  input  logic [XLEN-1:0] IMemRData,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCPlus8D,
  output logic            ValidD
);

  typedef enum logic [1:0] {StIdle, StReq, StDrop, StHold} fetchState_t;

  fetchState_t     stateQ, stateD;
  logic [XLEN-1:0] pcfQ, pcfD;
  logic [XLEN-1:0] pendPcQ, pendPcD;
  logic [XLEN-1:0] bufQ, bufD;
  logic [XLEN-1:0] instrNext, pcPlus8Next;
  logic            validNext;

  logic            redirect;
  logic [XLEN-1:0] targetRaw, target;
  logic            deliver;
  logic [XLEN-1:0] deliverWord;

  assign redirect  = PCSrcW | BranchTakenE;
  assign targetRaw = PCSrcW ? ResultW : ALUResultE;
  assign target    = {targetRaw[XLEN-1:2], 2'b00};

  // PCF only moves once the outstanding request is acked, so the address stays stable in DROP.
  assign IMemAddr = pcfQ;

  always_comb begin
    stateD      = stateQ;
    pcfD        = pcfQ;
    pendPcD     = pendPcQ;
    bufD        = bufQ;
    IMemReq     = 1'b0;
    deliver     = 1'b0;
    deliverWord = IMemRData;
    case (stateQ)
      StIdle: begin
        stateD = StReq;
        if (redirect) pcfD = target;
      end
      StReq: begin
        IMemReq = 1'b1;
        if (IMemAck) begin
          if (redirect) begin
            pcfD = target;
          end else if (!FlushD) begin
            if (StallD) begin
              bufD   = IMemRData;
              stateD = StHold;
            end else begin
              deliver = 1'b1;
            end
          end
        end else if (redirect) begin
          pendPcD = target;
          stateD  = StDrop;
        end
      end
      StDrop: begin
        IMemReq = 1'b1;
        if (redirect) pendPcD = target;
        if (IMemAck) begin
          pcfD   = redirect ? target : pendPcQ;
          stateD = StReq;
        end
      end
      StHold: begin
        deliverWord = bufQ;
        if (redirect) begin
          pcfD   = target;
          stateD = StReq;
        end else if (FlushD) begin
          stateD = StReq;
        end else if (!StallD) begin
          deliver = 1'b1;
          stateD  = StReq;
        end
      end
      default: stateD = StIdle;
    endcase
    if (deliver) pcfD = pcfQ + XLEN'(4);
  end

  always_comb begin
    instrNext   = InstrD;
    pcPlus8Next = PCPlus8D;
    validNext   = ValidD;
    if (FlushD) begin
      instrNext = '0;
      validNext = 1'b0;
    end else if (StallD) begin
      instrNext = InstrD;
    end else if (deliver) begin
      instrNext   = deliverWord;
      pcPlus8Next = pcfQ + XLEN'(8);
      validNext   = 1'b1;
    end else begin
      instrNext = '0;
      validNext = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateQ   <= StIdle;
      pcfQ     <= RESET_PC;
      pendPcQ  <= '0;
      bufQ     <= '0;
      InstrD   <= '0;
      PCPlus8D <= '0;
      ValidD   <= 1'b0;
    end else begin
      stateQ   <= stateD;
      pcfQ     <= pcfD;
      pendPcQ  <= pendPcD;
      bufQ     <= bufD;
      InstrD   <= instrNext;
      PCPlus8D <= pcPlus8Next;
      ValidD   <= validNext;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table, hand-written multi-cycle corner cases, then random
// stimulus checked against an instruction-stream model of the fetch stage.
module tb_fetch_stage;
  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] Z        = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        StallD = 1'b0, FlushD = 1'b0, BranchTakenE = 1'b0, PCSrcW = 1'b0;
  logic [31:0] ALUResultE = '0, ResultW = '0;
  logic        IMemReq, IMemAck = 1'b0, ValidD;
  logic [31:0] IMemAddr, IMemRData = '0, InstrD, PCPlus8D;

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .StallD(StallD), .FlushD(FlushD),
    .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE), .PCSrcW(PCSrcW),
    .ResultW(ResultW), .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck),
    .IMemRData(IMemRData), .InstrD(InstrD), .PCPlus8D(PCPlus8D), .ValidD(ValidD)
  );

  typedef struct {
    bit st, fl, bt; logic [31:0] alu; bit pc; logic [31:0] rw;
    bit eReq; logic [31:0] eAddr; bit eValid; logic [31:0] eInstr, ePc8;
  } vec_t;

  vec_t vecs[15];
  int   testsRun = 0, testsFailed = 0;
  int   memLat = 1, memCnt = 0;
  bit   strayAck = 1'b0, forceAck = 1'b0;
  logic [31:0] forceData = '0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'hE000_0000 + a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: acks a request after memLat cycles of it being held; optional stray acks.
  task automatic memDrive();
    if (forceAck) begin
      IMemAck   = 1'b1;
      IMemRData = forceData;
      memCnt    = 0;
    end else if (IMemReq) begin
      memCnt++;
      if (memCnt >= memLat) begin
        IMemAck   = 1'b1;
        IMemRData = memWord(IMemAddr);
        memCnt    = 0;
      end else begin
        IMemAck   = 1'b0;
        IMemRData = $urandom;
      end
    end else begin
      memCnt    = 0;
      IMemAck   = strayAck && ($urandom_range(0, 2) == 0);
      IMemRData = $urandom;
    end
  endtask

  task automatic setCtl(input bit st, input bit fl, input bit bt, input logic [31:0] alu,
                        input bit pc, input logic [31:0] rw);
    StallD = st; FlushD = fl; BranchTakenE = bt; ALUResultE = alu; PCSrcW = pc; ResultW = rw;
  endtask

  task automatic stepIdle();
    setCtl(1'b0, 1'b0, 1'b0, Z, 1'b0, Z);
    memDrive();
    tick();
  endtask

  task automatic doReset();
    reset = 1'b0; forceAck = 1'b0; strayAck = 1'b0;
    setCtl(1'b0, 1'b0, 1'b0, Z, 1'b0, Z);
    IMemAck = 1'b0;
    tick();
    tick();
    reset  = 1'b1;
    memCnt = 0;
  endtask

  logic [31:0] expPC, lastInstr, lastPc8, pTarget, pAddr;
  bit          lastValid, pStall, pFlush, pRedir, pReq, pAck;
  bit          st, fl, bt, pc;
  logic [31:0] alu, rw;
  int          newCount;

  initial begin
    // st fl bt alu pc rw | req addr valid instr pc8 ; zero-wait memory from reset
    vecs[0]  = '{1'b0, 1'b0, 1'b0, Z, 1'b0, Z, 1'b0, 32'h0, 1'b0, Z, Z};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, Z, 1'b0, Z, 1'b1, 32'h0, 1'b0, Z, Z};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, Z, 1'b0, Z, 1'b1, 32'h4, 1'b1, 32'hE000_0000, 32'h8};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, Z, 1'b0, Z, 1'b1, 32'h8, 1'b1, 32'hE000_0004, 32'hC};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, Z, 1'b0, Z, 1'b0, 32'h8, 1'b1, 32'hE000_0004, 32'hC};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, Z, 1'b0, Z, 1'b0, 32'h8, 1'b1, 32'hE000_0004, 32'hC};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, Z, 1'b0, Z, 1'b0, 32'h8, 1'b1, 32'hE000_0004, 32'hC};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, Z, 1'b0, Z, 1'b1, 32'hC, 1'b1, 32'hE000_0008, 32'h10};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, Z, 1'b0, Z, 1'b1, 32'hC, 1'b0, Z, 32'h10};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h200,
                 1'b1, 32'h10, 1'b1, 32'hE000_000C, 32'h14};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h103, 1'b0, Z, 1'b1, 32'h200, 1'b0, Z, 32'h14};
    vecs[11] = '{1'b0, 1'b0, 1'b0, Z, 1'b0, Z, 1'b1, 32'h100, 1'b0, Z, 32'h14};
    vecs[12] = '{1'b0, 1'b1, 1'b0, Z, 1'b0, Z, 1'b1, 32'h104, 1'b1, 32'hE000_0100, 32'h108};
    vecs[13] = '{1'b0, 1'b0, 1'b0, Z, 1'b0, Z, 1'b1, 32'h104, 1'b0, Z, 32'h108};
    vecs[14] = '{1'b0, 1'b0, 1'b0, Z, 1'b0, Z, 1'b1, 32'h108, 1'b1, 32'hE000_0104, 32'h10C};

    doReset();
    memLat = 1;
    for (int i = 0; i < 15; i++) begin
      checkBit($sformatf("vec%0d IMemReq", i), IMemReq, vecs[i].eReq);
      check($sformatf("vec%0d IMemAddr", i), IMemAddr, vecs[i].eAddr);
      checkBit($sformatf("vec%0d ValidD", i), ValidD, vecs[i].eValid);
      check($sformatf("vec%0d InstrD", i), InstrD, vecs[i].eInstr);
      check($sformatf("vec%0d PCPlus8D", i), PCPlus8D, vecs[i].ePc8);
      setCtl(vecs[i].st, vecs[i].fl, vecs[i].bt, vecs[i].alu, vecs[i].pc, vecs[i].rw);
      memDrive();
      tick();
    end

    // Redirect while a 3-cycle request to 0x20 is in flight
    doReset();
    memLat = 3;
    setCtl(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, Z); memDrive(); tick();
    check("inflight addr c1", IMemAddr, 32'h20);
    stepIdle();
    setCtl(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, Z); memDrive(); tick();
    checkBit("inflight req c3", IMemReq, 1'b1);
    check("inflight addr c3", IMemAddr, 32'h20);
    stepIdle();
    check("inflight addr c4", IMemAddr, 32'h100);
    checkBit("inflight ValidD c4", ValidD, 1'b0);
    stepIdle(); stepIdle(); stepIdle();
    checkBit("inflight ValidD c7", ValidD, 1'b1);
    check("inflight InstrD c7", InstrD, 32'hE000_0100);
    check("inflight PCPlus8D c7", PCPlus8D, 32'h108);

    // Reset while in DROP with an ack arriving, then a late ack in IDLE
    doReset();
    memLat = 3;
    setCtl(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, Z); memDrive(); tick();
    setCtl(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, Z); memDrive(); tick();
    check("rstdrop addr before", IMemAddr, 32'h80);
    reset = 1'b0; forceAck = 1'b1; forceData = 32'h0BAD_0BAD;
    setCtl(1'b0, 1'b0, 1'b0, Z, 1'b0, Z); memDrive(); tick();
    reset = 1'b1;
    checkBit("rstdrop IMemReq", IMemReq, 1'b0);
    check("rstdrop IMemAddr", IMemAddr, RESET_PC);
    checkBit("rstdrop ValidD", ValidD, 1'b0);
    memDrive(); tick();
    forceAck = 1'b0;
    check("late ack InstrD", InstrD, Z);
    checkBit("late ack ValidD", ValidD, 1'b0);
    check("late ack addr", IMemAddr, RESET_PC);
    stepIdle(); stepIdle(); stepIdle();
    check("rstdrop first InstrD", InstrD, memWord(RESET_PC));
    checkBit("rstdrop first ValidD", ValidD, 1'b1);

    // Random stimulus against the instruction-stream model
    doReset();
    strayAck = 1'b1;
    expPC = RESET_PC; lastInstr = '0; lastPc8 = '0; lastValid = 1'b0;
    pStall = 1'b0; pFlush = 1'b0; pRedir = 1'b0; pTarget = '0;
    pReq = 1'b0; pAck = 1'b0; pAddr = '0; newCount = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) memLat = $urandom_range(1, 3);
      if (pFlush) begin
        checkBit("rnd flush ValidD", ValidD, 1'b0);
        check("rnd flush InstrD", InstrD, Z);
      end else if (pStall) begin
        checkBit("rnd stall ValidD", ValidD, lastValid);
        check("rnd stall InstrD", InstrD, lastInstr);
        check("rnd stall PCPlus8D", PCPlus8D, lastPc8);
      end else if (ValidD) begin
        check($sformatf("rnd InstrD @%h", expPC), InstrD, memWord(expPC));
        check($sformatf("rnd PCPlus8D @%h", expPC), PCPlus8D, expPC + 32'd8);
        expPC = expPC + 32'd4;
        newCount++;
      end else begin
        check("rnd bubble InstrD", InstrD, Z);
      end
      if (pRedir) expPC = {pTarget[31:2], 2'b00};
      if (pReq && !pAck) begin
        checkBit("rnd req held", IMemReq, 1'b1);
        check("rnd addr stable", IMemAddr, pAddr);
      end
      check("rnd addr aligned", {30'd0, IMemAddr[1:0]}, Z);
      lastValid = ValidD; lastInstr = InstrD; lastPc8 = PCPlus8D;
      st  = ($urandom_range(0, 4) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      bt  = ($urandom_range(0, 11) == 0);
      pc  = ($urandom_range(0, 19) == 0);
      alu = $urandom;
      rw  = $urandom;
      setCtl(st, fl, bt, alu, pc, rw);
      memDrive();
      pStall = st; pFlush = fl; pRedir = bt | pc; pTarget = pc ? rw : alu;
      pReq = IMemReq; pAck = IMemAck; pAddr = IMemAddr;
      tick();
    end
    checkBit("rnd enough deliveries", newCount >= 100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
